// File: rtl/rom_bist_sig_ctrl_if.sv
// Bus between the ROM BIST sequencer and its environment: the DFX control/status pins
// and the ROM wrapper's BIST read port.
interface rom_bist_sig_ctrl_if #(
    parameter int unsigned ROM_ADDR = 11,
    parameter int unsigned ROM_BITS = 32
);
    logic                BIST_START;
    logic                BIST_ABORT;
    logic [ROM_BITS-1:0] BIST_EXP_SIGN;
    logic [ROM_BITS-1:0] DATA_ROM_OUT;
    logic                BIST_ROM_ENABLE;
    logic [ROM_ADDR-1:0] BIST_ADDR_ROM_IN;
    logic                BIST_REN_ROM;
    logic                BIST_BUSY;
    logic                BIST_DONE;
    logic                BIST_PASS;
    logic [ROM_BITS-1:0] BIST_SIGN;

    modport master (
        input  BIST_START, BIST_ABORT, BIST_EXP_SIGN, DATA_ROM_OUT,
        output BIST_ROM_ENABLE, BIST_ADDR_ROM_IN, BIST_REN_ROM,
               BIST_BUSY, BIST_DONE, BIST_PASS, BIST_SIGN
    );

    modport slave (
        output BIST_START, BIST_ABORT, BIST_EXP_SIGN, DATA_ROM_OUT,
        input  BIST_ROM_ENABLE, BIST_ADDR_ROM_IN, BIST_REN_ROM,
               BIST_BUSY, BIST_DONE, BIST_PASS, BIST_SIGN
    );
endinterface

// File: rtl/rom_bist_sig_ctrl.sv
// ROM BIST sequencer: reads every ROM word in address order, folds the data into a MISR
// and compares the final signature against the expected value.
module rom_bist_sig_ctrl #(
    parameter int unsigned         ROM_ADDR  = 11,
    parameter int unsigned         ROM_WORDS = 2048,
    parameter int unsigned         ROM_BITS  = 32,
    parameter int unsigned         RD_LAT    = 1,
    parameter int unsigned         SETUP_CYC = 4,
    parameter logic [ROM_BITS-1:0] MISR_POLY = ROM_BITS'(32'h04C11DB7),
    parameter logic [ROM_BITS-1:0] MISR_SEED = ROM_BITS'(32'hFFFFFFFF)
) (
    input logic                 BIST_CLK_ROM_IN,
    input logic                 BIST_RST_ROM_IN,
    rom_bist_sig_ctrl_if.master bist
);
    localparam int unsigned CNT_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_READ,
        ST_DRAIN,
        ST_CMP,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROM_ADDR-1:0] addr_q, addr_d;
    logic                en_q, en_d;
    logic                ren_q, ren_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [ROM_BITS-1:0] misr_q, misr_d;
    logic [ROM_BITS-1:0] misr_step;

    assign misr_step = {misr_q[ROM_BITS-2:0], 1'b0}
                     ^ (misr_q[ROM_BITS-1] ? MISR_POLY : '0)
                     ^ bist.DATA_ROM_OUT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        en_d    = en_q;
        ren_d   = ren_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        vld_d   = RD_LAT'({vld_q, ren_q});
        misr_d  = vld_q[RD_LAT-1] ? misr_step : misr_q;

        // Abort drops everything except the signature, which stays readable for debug.
        if (bist.BIST_ABORT && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            addr_d  = '0;
            en_d    = 1'b0;
            ren_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            vld_d   = '0;
            misr_d  = misr_q;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bist.BIST_START) begin
                        state_d = ST_SETUP;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        misr_d  = MISR_SEED;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                        state_d = ST_READ;
                        ren_d   = 1'b1;
                        addr_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_READ: begin
                    if (addr_q == ROM_ADDR'(ROM_WORDS - 1)) begin
                        state_d = ST_DRAIN;
                        ren_d   = 1'b0;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Leave on the edge that performs the last MISR update.
                    if (vld_d == '0) begin
                        state_d = ST_CMP;
                    end
                end
                ST_CMP: begin
                    state_d = ST_DONE;
                    pass_d  = (misr_q == bist.BIST_EXP_SIGN);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    en_d    = 1'b0;
                end
                ST_DONE: begin
                    if (!bist.BIST_START) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge BIST_CLK_ROM_IN) begin
        if (BIST_RST_ROM_IN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            ren_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            vld_q   <= '0;
            misr_q  <= MISR_SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            ren_q   <= ren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            vld_q   <= vld_d;
            misr_q  <= misr_d;
        end
    end

    assign bist.BIST_ROM_ENABLE  = en_q;
    assign bist.BIST_ADDR_ROM_IN = addr_q;
    assign bist.BIST_REN_ROM     = ren_q;
    assign bist.BIST_BUSY        = busy_q;
    assign bist.BIST_DONE        = done_q;
    assign bist.BIST_PASS        = pass_q;
    assign bist.BIST_SIGN        = misr_q;
endmodule

// File: tb/tb_rom_bist_sig_ctrl.sv
// Directed bench for rom_bist_sig_ctrl: four parameterisations, each with its own ROM model.
module tb_rom_bist_sig_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rom_bist_sig_ctrl_if ifa ();
    rom_bist_sig_ctrl_if ifb ();
    rom_bist_sig_ctrl_if ifc ();
    rom_bist_sig_ctrl_if ifd ();

    rom_bist_sig_ctrl #(.ROM_WORDS(1), .RD_LAT(1), .SETUP_CYC(1)) u_a (
        .BIST_CLK_ROM_IN(clk), .BIST_RST_ROM_IN(rst), .bist(ifa));
    rom_bist_sig_ctrl #(.ROM_WORDS(2), .SETUP_CYC(1), .MISR_SEED(32'h0)) u_b (
        .BIST_CLK_ROM_IN(clk), .BIST_RST_ROM_IN(rst), .bist(ifb));
    rom_bist_sig_ctrl u_c (
        .BIST_CLK_ROM_IN(clk), .BIST_RST_ROM_IN(rst), .bist(ifc));
    rom_bist_sig_ctrl #(.ROM_WORDS(4), .RD_LAT(3)) u_d (
        .BIST_CLK_ROM_IN(clk), .BIST_RST_ROM_IN(rst), .bist(ifd));

    function automatic logic [31:0] rom_d_word(input logic [10:0] a);
        return 32'hC0DE_0000 ^ {21'h0, a} ^ {a[1:0], 30'h0};
    endfunction

    // ROM models: single-cycle for a/b/c, three-stage pipeline for d.
    logic [31:0] d_s1, d_s2;
    always @(posedge clk) begin
        if (rst) begin
            ifa.DATA_ROM_OUT <= '0;
            ifb.DATA_ROM_OUT <= '0;
            ifc.DATA_ROM_OUT <= '0;
            ifd.DATA_ROM_OUT <= '0;
            d_s1 <= '0;
            d_s2 <= '0;
        end else begin
            if (ifa.BIST_REN_ROM) ifa.DATA_ROM_OUT <= 32'h0;
            if (ifb.BIST_REN_ROM) ifb.DATA_ROM_OUT <= {21'h0, ifb.BIST_ADDR_ROM_IN} + 32'd1;
            if (ifc.BIST_REN_ROM) ifc.DATA_ROM_OUT <= {21'h0, ifc.BIST_ADDR_ROM_IN};
            if (ifd.BIST_REN_ROM) d_s1 <= rom_d_word(ifd.BIST_ADDR_ROM_IN);
            d_s2 <= d_s1;
            ifd.DATA_ROM_OUT <= d_s2;
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [4:0] got, input logic [4:0] exp);
        chk(tag, 32'(got), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status as {ENABLE, REN, BUSY, DONE, PASS}.
    function automatic logic [4:0] st_a();
        return {ifa.BIST_ROM_ENABLE, ifa.BIST_REN_ROM, ifa.BIST_BUSY, ifa.BIST_DONE, ifa.BIST_PASS};
    endfunction
    function automatic logic [4:0] st_b();
        return {ifb.BIST_ROM_ENABLE, ifb.BIST_REN_ROM, ifb.BIST_BUSY, ifb.BIST_DONE, ifb.BIST_PASS};
    endfunction
    function automatic logic [4:0] st_c();
        return {ifc.BIST_ROM_ENABLE, ifc.BIST_REN_ROM, ifc.BIST_BUSY, ifc.BIST_DONE, ifc.BIST_PASS};
    endfunction
    function automatic logic [4:0] st_d();
        return {ifd.BIST_ROM_ENABLE, ifd.BIST_REN_ROM, ifd.BIST_BUSY, ifd.BIST_DONE, ifd.BIST_PASS};
    endfunction

    function automatic logic [31:0] misr_ref(input logic [31:0] m, input logic [31:0] d);
        logic [31:0] r;
        r = m << 1;
        if (m[31]) r = r ^ 32'h04C11DB7;
        return r ^ d;
    endfunction

    // Full run on the 2048-word instance; cycle 1 is the edge that samples START.
    task automatic run_c(input logic [31:0] ref_sign, input bit hold, input bit poke);
        int unsigned cyc, n_ren, n_setup, addr_err;
        bit seen_done;
        ifc.BIST_EXP_SIGN = ref_sign;
        ifc.BIST_START = 1'b1;
        tick();
        cyc = 1;
        chk("c_reseed", ifc.BIST_SIGN, 32'hFFFF_FFFF);
        if (!hold) ifc.BIST_START = 1'b0;
        n_ren = 0; n_setup = 0; addr_err = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 3000) begin
            if (ifc.BIST_REN_ROM) begin
                if (32'(ifc.BIST_ADDR_ROM_IN) != n_ren) addr_err++;
                n_ren++;
                if (poke) ifc.BIST_START = (n_ren == 32'h50);
            end else if (ifc.BIST_ROM_ENABLE && n_ren == 0) begin
                n_setup++;
            end
            tick();
            cyc++;
            seen_done = ifc.BIST_DONE;
        end
        chk("c_done_edge", cyc, 32'd2055);
        chk("c_ren_count", n_ren, 32'd2048);
        chk("c_setup_cyc", n_setup, 32'd4);
        chk("c_addr_seq", addr_err, 32'd0);
        chk("c_sign", ifc.BIST_SIGN, ref_sign);
        chk_st("c_done_st", st_c(), 5'b00011);
        if (hold) begin
            repeat (5) tick();
            chk_st("c_hold_st", st_c(), 5'b00011);
            ifc.BIST_START = 1'b0;
        end
        tick();
        chk_st("c_idle_st", st_c(), 5'b00000);
    endtask

    task automatic run_d(output int unsigned cyc, output int unsigned tail);
        bit seen_ren, seen_done;
        ifd.BIST_START = 1'b1;
        tick();
        ifd.BIST_START = 1'b0;
        cyc = 1; tail = 0; seen_ren = 1'b0; seen_done = 1'b0;
        while (!seen_done && cyc < 200) begin
            if (ifd.BIST_REN_ROM) seen_ren = 1'b1;
            else if (seen_ren && ifd.BIST_BUSY) tail++;
            tick();
            cyc++;
            seen_done = ifd.BIST_DONE;
        end
    endtask

    initial begin
        logic [31:0] ref_c, ref_d, sign_prev;
        int unsigned cyc, tail;
        bit found;

        ifa.BIST_START = 0; ifa.BIST_ABORT = 0; ifa.BIST_EXP_SIGN = '0;
        ifb.BIST_START = 0; ifb.BIST_ABORT = 0; ifb.BIST_EXP_SIGN = '0;
        ifc.BIST_START = 0; ifc.BIST_ABORT = 0; ifc.BIST_EXP_SIGN = '0;
        ifd.BIST_START = 0; ifd.BIST_ABORT = 0; ifd.BIST_EXP_SIGN = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        chk_st("rst_st", st_a(), 5'b00000);
        chk("rst_addr", 32'(ifa.BIST_ADDR_ROM_IN), 32'd0);
        chk("rst_sign", ifa.BIST_SIGN, 32'hFFFF_FFFF);
        chk("rst_sign_b", ifb.BIST_SIGN, 32'h0);

        // Single word of zero: signature is seed shifted and reduced once.
        ifa.BIST_EXP_SIGN = 32'hFB3E_E249;
        ifa.BIST_START = 1'b1;
        tick();
        ifa.BIST_START = 1'b0;
        chk_st("a_setup", st_a(), 5'b10100);
        tick();
        chk_st("a_read", st_a(), 5'b11100);
        chk("a_addr", 32'(ifa.BIST_ADDR_ROM_IN), 32'd0);
        tick();
        chk_st("a_drain", st_a(), 5'b10100);
        tick();
        chk_st("a_cmp", st_a(), 5'b10100);
        chk("a_sign", ifa.BIST_SIGN, 32'hFB3E_E249);
        tick();
        chk_st("a_done", st_a(), 5'b00011);
        tick();
        chk_st("a_idle", st_a(), 5'b00000);

        // Two words {1,2} from seed 0: 0 -> 1 -> 0.
        ifb.BIST_EXP_SIGN = 32'h0;
        ifb.BIST_START = 1'b1;
        tick();
        ifb.BIST_START = 1'b0;
        tick();
        chk("b_addr0", 32'(ifb.BIST_ADDR_ROM_IN), 32'd0);
        tick();
        chk("b_addr1", 32'(ifb.BIST_ADDR_ROM_IN), 32'd1);
        tick();
        chk("b_sign_w0", ifb.BIST_SIGN, 32'h1);
        tick();
        chk("b_sign_fin", ifb.BIST_SIGN, 32'h0);
        tick();
        chk_st("b_pass", st_b(), 5'b00011);
        tick();
        ifb.BIST_EXP_SIGN = 32'h1;
        ifb.BIST_START = 1'b1;
        tick();
        ifb.BIST_START = 1'b0;
        repeat (5) tick();
        chk_st("b_fail_done", st_b(), 5'b00010);
        tick();

        // Default instance, data = address; includes a START pulse mid-READ.
        ref_c = 32'hFFFF_FFFF;
        for (int i = 0; i < 2048; i++) ref_c = misr_ref(ref_c, 32'(i));
        run_c(ref_c, 1'b0, 1'b1);

        // Abort at address 0x100.
        ifc.BIST_START = 1'b1;
        tick();
        ifc.BIST_START = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (ifc.BIST_REN_ROM && ifc.BIST_ADDR_ROM_IN == 11'h100) found = 1'b1;
            else tick();
        end
        chk("c_abort_reached", 32'(found), 32'd1);
        sign_prev = ifc.BIST_SIGN;
        ifc.BIST_ABORT = 1'b1;
        tick();
        ifc.BIST_ABORT = 1'b0;
        chk_st("c_abort_st", st_c(), 5'b00000);
        chk("c_abort_sign", ifc.BIST_SIGN, sign_prev);
        tick();

        // Full rerun with START held through DONE.
        run_c(ref_c, 1'b1, 1'b0);

        // RD_LAT=3, four words: DRAIN(3)+CMP(1) after the last read.
        ref_d = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) ref_d = misr_ref(ref_d, rom_d_word(11'(i)));
        ifd.BIST_EXP_SIGN = ref_d;
        run_d(cyc, tail);
        chk("d_done_edge", cyc, 32'd13);
        chk("d_tail_cyc", tail, 32'd4);
        chk("d_sign", ifd.BIST_SIGN, ref_d);
        chk_st("d_done", st_d(), 5'b00011);

        // Reset in DONE.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_st("d_rst_done_st", st_d(), 5'b00000);
        chk("d_rst_done_sign", ifd.BIST_SIGN, 32'hFFFF_FFFF);

        // Reset in the first DRAIN cycle.
        ifd.BIST_START = 1'b1;
        tick();
        ifd.BIST_START = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (ifd.BIST_REN_ROM) found = 1'b1;
        end
        for (int i = 0; i < 100 && ifd.BIST_REN_ROM; i++) tick();
        chk_st("d_drain_st", st_d(), 5'b10100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_st("d_rst_drain_st", st_d(), 5'b00000);
        chk("d_rst_drain_sign", ifd.BIST_SIGN, 32'hFFFF_FFFF);
        chk("d_rst_drain_addr", 32'(ifd.BIST_ADDR_ROM_IN), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
